// File: rtl/response_serializer_if.sv
// Handshake and TX FIFO signals between the command interpreter, the response
// serializer and the UART transmit FIFO.
interface response_serializer_if #(
    parameter int WORD_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_data;
    logic [2:0]            in_bytes;
    logic                  fifo_full;
    logic                  fifo_write;
    logic [BYTE_WIDTH-1:0] fifo_write_data;
    logic                  busy;
    logic                  done;

    modport master (
        output in_valid, in_data, in_bytes, fifo_full,
        input  in_ready, fifo_write, fifo_write_data, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_bytes, fifo_full,
        output in_ready, fifo_write, fifo_write_data, busy, done
    );
endinterface

// File: rtl/response_serializer.sv
// Splits accepted response words into 1..N bytes and writes them one per cycle
// into the UART TX FIFO, honouring FIFO back-pressure and wire byte order.
module response_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    response_serializer_if.slave bus
);
    localparam int NB = WORD_WIDTH / BYTE_WIDTH;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state, next_state;
    logic [WORD_WIDTH-1:0] shift_reg, load_word, shifted;
    logic [CW-1:0]         count, load_count;
    logic                  done_q;
    logic                  accept, write;

    // A byte count of 0 (or anything beyond the word) means the whole word.
    always_comb begin
        if (bus.in_bytes == 3'd0 || int'(bus.in_bytes) > NB)
            load_count = CW'(NB);
        else
            load_count = CW'(bus.in_bytes);
    end

    // MSB-first parks the top selected byte in the upper lane; LSB-first uses the low lane.
    assign load_word = MSB_FIRST ? (bus.in_data << (BYTE_WIDTH * (NB - int'(load_count))))
                                 : bus.in_data;
    assign shifted   = MSB_FIRST ? (shift_reg << BYTE_WIDTH) : (shift_reg >> BYTE_WIDTH);

    assign bus.fifo_write_data = MSB_FIRST ? shift_reg[WORD_WIDTH-1 -: BYTE_WIDTH]
                                           : shift_reg[BYTE_WIDTH-1:0];
    assign bus.done = done_q;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state     = state;
        bus.in_ready   = 1'b0;
        bus.busy       = 1'b0;
        bus.fifo_write = 1'b0;
        accept         = 1'b0;
        write          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                bus.busy = 1'b1;
                // Gating with reset keeps an aborted word from leaking one more byte.
                if (!bus.fifo_full && !reset) begin
                    bus.fifo_write = 1'b1;
                    write          = 1'b1;
                    if (count == CW'(1))
                        next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            count     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= write && (count == CW'(1));
            if (accept) begin
                shift_reg <= load_word;
                count     <= load_count;
            end else if (write) begin
                shift_reg <= shifted;
                count     <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_response_serializer.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) share one stimulus
// stream; a negedge monitor checks every written byte and every done pulse.
module tb_response_serializer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [2:0]  in_bytes;
    logic        man_ff, rand_ff, rand_full;
    logic        fifo_full;

    int compared = 0;
    int mismatched = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    bit   pend [2];

    always #5 clk = ~clk;

    response_serializer_if #(.WORD_WIDTH(32), .BYTE_WIDTH(8)) if_m ();
    response_serializer_if #(.WORD_WIDTH(32), .BYTE_WIDTH(8)) if_l ();

    assign fifo_full = rand_full ? rand_ff : man_ff;

    assign if_m.in_valid  = in_valid;
    assign if_m.in_data   = in_data;
    assign if_m.in_bytes  = in_bytes;
    assign if_m.fifo_full = fifo_full;
    assign if_l.in_valid  = in_valid;
    assign if_l.in_data   = in_data;
    assign if_l.in_bytes  = in_bytes;
    assign if_l.fifo_full = fifo_full;

    response_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .bus(if_m.slave));
    response_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .bus(if_l.slave));

    logic       fw [2];
    logic [7:0] fd [2];
    logic       dn [2];
    assign fw[0] = if_m.fifo_write;
    assign fw[1] = if_l.fifo_write;
    assign fd[0] = if_m.fifo_write_data;
    assign fd[1] = if_l.fifo_write_data;
    assign dn[0] = if_m.done;
    assign dn[1] = if_l.done;

    initial begin
        rand_ff = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rand_ff = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                bit   nxt;
                exp_t e;
                nxt = 1'b0;
                compared++;
                if (dn[i] !== pend[i]) begin
                    mismatched++;
                    $display("FAIL done[%0d]: got %b want %b at %0t", i, dn[i], pend[i], $time);
                end
                if (fw[i] === 1'b1) begin
                    compared++;
                    if (fifo_full !== 1'b0) begin
                        mismatched++;
                        $display("FAIL write_while_full[%0d]: fifo_write 1 want 0 at %0t", i, $time);
                    end
                    compared++;
                    if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
                        mismatched++;
                        $display("FAIL extra_write[%0d]: byte %h written, none expected at %0t", i, fd[i], $time);
                    end else begin
                        if (i == 0) e = qa.pop_front();
                        else        e = qb.pop_front();
                        if (fd[i] !== e.b) begin
                            mismatched++;
                            $display("FAIL byte[%0d]: got %h want %h at %0t", i, fd[i], e.b, $time);
                        end
                        nxt = e.last;
                    end
                end
                pend[i] = nxt;
            end
        end
    end

    task automatic push_word(input logic [31:0] d, input int nb);
        int   n;
        exp_t e;
        n = (nb == 0) ? 4 : nb;
        for (int k = 0; k < n; k++) begin
            e.b    = d[8*(n-1-k) +: 8];
            e.last = (k == n - 1);
            qa.push_back(e);
            e.b    = d[8*k +: 8];
            qb.push_back(e);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input int nb);
        bit ok;
        ok       = 1'b0;
        in_data  = d;
        in_bytes = 3'(nb);
        in_valid = 1'b1;
        push_word(d, nb);
        for (int t = 0; t < 100; t++) begin
            if (if_m.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        in_bytes = 3'($urandom_range(0, 7));
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: in_ready 0 want 1 within 100 cycles");
        end
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < bound; t++) begin
            if (if_m.busy === 1'b0 && if_l.busy === 1'b0 && qa.size() == 0 && qb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL idle_timeout: pending bytes %0d/%0d want 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bytes  = '0;
        man_ff    = 1'b0;
        rand_full = 1'b0;
        pend[0]   = 1'b0;
        pend[1]   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared += 5;
        if (if_m.in_ready !== 1'b1 || if_l.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b/%b want 1", if_m.in_ready, if_l.in_ready);
        end
        if (if_m.busy !== 1'b0 || if_l.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_busy: got %b/%b want 0", if_m.busy, if_l.busy);
        end
        if (fw[0] !== 1'b0 || fw[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_fifo_write: got %b/%b want 0", fw[0], fw[1]);
        end
        if (dn[0] !== 1'b0 || dn[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_done: got %b/%b want 0", dn[0], dn[1]);
        end
        if (fd[0] !== 8'h00 || fd[1] !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_data: got %h/%h want 00", fd[0], fd[1]);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_msb_basic;
        send_word(32'hAABBCCDD, 4);
        compared += 2;
        if (fw[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL first_write_latency: fifo_write %b want 1", fw[0]);
        end
        if (if_m.in_ready !== 1'b0 || if_m.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL send_flags: in_ready %b busy %b want 0 1", if_m.in_ready, if_m.busy);
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        compared++;
        if (if_m.in_ready !== 1'b1 || if_m.busy !== 1'b0 || qa.size() != 0) begin
            mismatched++;
            $display("FAIL after_4_writes: in_ready %b busy %b left %0d want 1 0 0",
                     if_m.in_ready, if_m.busy, qa.size());
        end
        wait_idle(20);
    endtask

    task automatic test_lsb_counts;
        send_word(32'h11223344, 2);
        wait_idle(20);
        send_word(32'h11223344, 0);
        wait_idle(20);
        send_word(32'h11223344, 3);
        wait_idle(20);
    endtask

    task automatic test_backpressure;
        send_word(32'hDEADBEEF, 4);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        man_ff = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            compared++;
            if (fw[0] !== 1'b0 || fd[0] !== 8'hBE || fd[1] !== 8'hAD) begin
                mismatched++;
                $display("FAIL hold_byte: write %b data %h/%h want 0 BE/AD", fw[0], fd[0], fd[1]);
            end
            @(posedge clk);
            #1;
        end
        man_ff = 1'b0;
        wait_idle(20);
    endtask

    task automatic test_back_to_back;
        send_word(32'h01020304, 4);
        in_data  = 32'h05060708;
        in_bytes = 3'd4;
        in_valid = 1'b1;
        push_word(32'h05060708, 4);
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (if_m.in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL ready_in_send: in_ready %b want 0 (cycle %0d)", if_m.in_ready, k);
            end
            @(posedge clk);
            #1;
        end
        compared++;
        if (if_m.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_gap: in_ready %b want 1", if_m.in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 32'hFFFFFFFF;
        wait_idle(20);
    endtask

    task automatic test_reset_mid;
        send_word(32'hCAFEF00D, 4);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        compared++;
        if (fw[0] !== 1'b0 || fw[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL write_in_reset: fifo_write %b/%b want 0", fw[0], fw[1]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        compared++;
        if (if_m.in_ready !== 1'b1 || if_m.busy !== 1'b0 || if_l.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL after_reset: in_ready %b busy %b/%b want 1 0/0",
                     if_m.in_ready, if_m.busy, if_l.busy);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send_word(32'h000000A5, 1);
        wait_idle(20);
    endtask

    task automatic test_random;
        rand_full = 1'b1;
        for (int w = 0; w < 1000; w++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            send_word($urandom, $urandom_range(0, 4));
        end
        wait_idle(400);
        rand_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_msb_basic();
        test_lsb_counts();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/response_serializer.md
Name: response_serializer

Overview:
- Transmit-side counterpart of the controller's byte-to-command assembly.
- Accepts 32-bit response words from the command interpreter (register reads, memory reads, status) over a valid/ready handshake.
- Splits each word into 1-4 bytes and writes them, one byte per cycle, into the TX FIFO that feeds the UART transmitter.
- Honours FIFO back-pressure, byte-order selection and reset mid-word.

Parameters:
WORD_WIDTH, 32, width of the input response word; must be a multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, width of each byte written to the TX FIFO; matches the UART payload width.
MSB_FIRST, 1, 1 = most significant selected byte sent first (big-endian on the wire); 0 = least significant first.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  response word available.
in_ready  output  1  serializer can accept a word this cycle.
in_data  input  WORD_WIDTH  response word.
in_bytes  input  3  number of low-order bytes of in_data to send: 1..4; 0 is treated as 4.
fifo_full  input  1  TX FIFO full flag.
fifo_write  output  1  TX FIFO write strobe; one byte per asserted cycle.
fifo_write_data  output  BYTE_WIDTH  byte to write.
busy  output  1  high while a word is being serialized.
done  output  1  one-cycle pulse the cycle after the last byte of a word is written.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clk is the clock. All state changes on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, fifo_write=0, fifo_write_data=0, busy=0, done=0, shift register=0, byte counter=0.
- States: IDLE and SEND.

IDLE:
- in_ready=1, busy=0.
- On in_valid && in_ready:
  - Latch in_data into the shift register, aligned so the first byte to send is at the output position.
  - Load the counter with the effective byte count (in_bytes, with 0 meaning 4).
  - Go to SEND.
- No FIFO write occurs in the accept cycle.

SEND:
- in_ready=0, busy=1.
- fifo_write = !fifo_full (combinational, so the write is never issued into a full FIFO).
- fifo_write_data = current byte.
- On a cycle with fifo_write=1: shift to the next byte and decrement the counter.
- When the counter reaches 0 on a write: return to IDLE, and pulse done in the following cycle.
- While fifo_full=1: hold the current byte and the counter; no write occurs.

Byte selection (n = effective count):
- Only in_data[8n-1:0] is sent.
- MSB_FIRST=1 order: byte n-1 down to byte 0.
- MSB_FIRST=0 order: byte 0 up to byte n-1.

Timing:
- Latency from accept to first fifo_write is 1 cycle (with FIFO not full).
- A 4-byte word occupies 4 write cycles with no back-pressure.
- in_ready reasserts in the cycle after the last write, giving one idle cycle between words.

Other rules:
- fifo_write_data holds the last driven byte when fifo_write=0; its value is don't-care when fifo_write=0.
- in_data and in_bytes are sampled only at the accept edge; changes afterwards have no effect.
- Simultaneous events: fifo_full rising in the same cycle as a would-be write suppresses that write; the byte is retried on the next not-full cycle.
- reset during SEND: remaining bytes are discarded, no further writes, done is not pulsed, and the FSM returns to IDLE next edge.
- No byte is ever duplicated or dropped under arbitrary fifo_full toggling.

Test Plan:
- Reset, then in_data=0xAABBCCDD, in_bytes=4, MSB_FIRST=1, fifo_full=0 -> fifo_write on 4 consecutive cycles starting 1 cycle after accept, bytes AA, BB, CC, DD; done pulses once the next cycle; in_ready returns high.
- MSB_FIRST=0, in_data=0x11223344, in_bytes=2 -> exactly 2 writes: 44 then 33; in_bytes=0 with the same data -> 4 writes: 44, 33, 22, 11.
- in_data=0xDEADBEEF, in_bytes=4, fifo_full=1 for 3 cycles after the second byte -> writes DE, AD, then 3 cycles with fifo_write=0 holding BE, then BE, EF; total 4 writes, no duplicates.
- Back-to-back in_valid with words 0x01020304 then 0x05060708 (in_bytes=4) -> second word is accepted only in the idle cycle after the 4th write; byte stream is 01..08 in order; in_ready is low throughout SEND.
- Assert reset after the 2nd byte of 0xCAFEF00D -> no further writes, done stays 0; the next word 0x000000A5 with in_bytes=1 produces a single write of A5.
- Random fifo_full toggling over 1000 random words and byte counts -> a scoreboard confirms the byte stream equals the expected byte order and fifo_write is never asserted while fifo_full=1.
